// File: rtl/jpeg_pkg.sv
// Shared definitions for the 2-D IDCT transpose stage.
//   BLOCK_DIM  : side of the square block (8)
//   IDX_W      : width of a row/column index within a block
//   SAT_MAX_W  : widest signed input the saturation helper accepts
//   channel_t  : colour component tag carried with each block
//   rd_state_t : read-side FSM states
//   sat()      : clamp a signed value to the range of an out_w-bit signed number
package jpeg_pkg;

  localparam int unsigned BLOCK_DIM = 8;
  localparam int unsigned IDX_W     = $clog2(BLOCK_DIM);
  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } channel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  // Result is returned at full width; the caller keeps the low out_w bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat(
    input logic signed [SAT_MAX_W-1:0] v,
    input int unsigned                 out_w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = $signed((SAT_MAX_W'(1) << (out_w - 1)) - SAT_MAX_W'(1));
    lo = ~hi;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/idct_tp_bank.sv
// One 8x8 storage bank of the transpose buffer.
//   clk        : clock
//   we_i       : write row_data_i into row row_i
//   row_i      : row index being written
//   row_data_i : row elements, index = column
//   col_i      : column index to read
//   col_data_o : column elements (combinational), index = row
module idct_tp_bank
  import jpeg_pkg::*;
#(
  parameter int unsigned OUT_W = 16
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [IDX_W-1:0]                row_i,
  input  logic [BLOCK_DIM-1:0][OUT_W-1:0] row_data_i,
  input  logic [IDX_W-1:0]                col_i,
  output logic [BLOCK_DIM-1:0][OUT_W-1:0] col_data_o
);

  // mem_q[row][col]; contents are don't-care after reset, so no reset term.
  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][OUT_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[row_i] <= row_data_i;
  end

  always_comb begin
    col_data_o = '0;
    for (int unsigned r = 0; r < BLOCK_DIM; r++) begin
      col_data_o[r] = mem_q[r][col_i];
    end
  end

endmodule

// File: rtl/idct_transpose_buffer.sv
// Ping-pong transpose buffer between the row and column IDCT passes.
// Rows of a block are saturated and written into one bank while the other
// bank is streamed out column by column.
//   clk, rst    : clock, asynchronous active-high reset
//   valid_in    : row present on idct_in
//   channel_in  : block tag, captured with row 0
//   idct_in     : row elements, index = column (signed IN_W)
//   in_ready    : current write bank is free
//   overflow    : sticky, a row arrived while in_ready was low
//   valid_out   : column present on col_out
//   out_ready   : downstream accepts the column
//   col_out     : column elements, index = row (signed OUT_W)
//   channel_out : tag of the block being emitted
module idct_transpose_buffer
  import jpeg_pkg::*;
#(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CH_W  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic [CH_W-1:0]                 channel_in,
  input  logic [BLOCK_DIM-1:0][IN_W-1:0]  idct_in,
  output logic                            in_ready,
  output logic                            overflow,
  output logic                            valid_out,
  input  logic                            out_ready,
  output logic [BLOCK_DIM-1:0][OUT_W-1:0] col_out,
  output logic [CH_W-1:0]                 channel_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_DIM - 1);

  // ---------------- write side ----------------
  logic [IDX_W-1:0]            wr_row_q, wr_row_d;
  logic                        wr_bank_q, wr_bank_d;
  logic [1:0]                  full_q, full_d;
  logic [1:0][CH_W-1:0]        tag_q, tag_d;
  logic                        overflow_q;
  logic [BLOCK_DIM-1:0][OUT_W-1:0] row_sat;
  logic                        wr_fire, wr_last;

  // ---------------- read side ----------------
  rd_state_t                   state_q, state_d;
  logic [IDX_W-1:0]            rd_col_q, rd_col_d;
  logic                        rd_bank_q, rd_bank_d;
  logic                        valid_q, valid_d;
  logic [BLOCK_DIM-1:0][OUT_W-1:0] col_q;
  logic [CH_W-1:0]             chan_q;
  logic                        load;
  logic                        ld_bank;
  logic [IDX_W-1:0]            ld_col;
  logic                        rd_release;
  logic [BLOCK_DIM-1:0][OUT_W-1:0] bank0_col, bank1_col, ld_data;
  logic [CH_W-1:0]             ld_tag;

  assign in_ready    = ~full_q[wr_bank_q];
  assign overflow    = overflow_q;
  assign valid_out   = valid_q;
  assign col_out     = col_q;
  assign channel_out = chan_q;

  assign wr_fire = valid_in & in_ready;
  assign wr_last = wr_fire & (wr_row_q == LAST_IDX);

  always_comb begin
    row_sat = '0;
    for (int unsigned c = 0; c < BLOCK_DIM; c++) begin
      row_sat[c] = OUT_W'(sat(SAT_MAX_W'($signed(idct_in[c])), OUT_W));
    end
  end

  idct_tp_bank #(.OUT_W(OUT_W)) u_bank0 (
    .clk        (clk),
    .we_i       (wr_fire & ~wr_bank_q),
    .row_i      (wr_row_q),
    .row_data_i (row_sat),
    .col_i      (ld_col),
    .col_data_o (bank0_col)
  );

  idct_tp_bank #(.OUT_W(OUT_W)) u_bank1 (
    .clk        (clk),
    .we_i       (wr_fire & wr_bank_q),
    .row_i      (wr_row_q),
    .row_data_i (row_sat),
    .col_i      (ld_col),
    .col_data_o (bank1_col)
  );

  // Write bookkeeping. A bank can never complete a write and a read on the
  // same edge: writes need full=0, reads need full=1.
  always_comb begin
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    tag_d     = tag_q;
    full_d    = full_q;
    if (wr_fire) begin
      wr_row_d = wr_last ? '0 : wr_row_q + IDX_W'(1);
      if (wr_row_q == '0) tag_d[wr_bank_q] = channel_in;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_release) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_row_q   <= wr_row_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      tag_q      <= tag_d;
      overflow_q <= overflow_q | (valid_in & ~in_ready);
    end
  end

  // Read FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_col_q  <= '0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      col_q     <= '0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_col_q  <= rd_col_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      if (load) begin
        col_q  <= ld_data;
        chan_q <= ld_tag;
      end
    end
  end

  // Read FSM: next state. The last column handshake can chain straight into
  // column 0 of the other bank so full-rate streaming has no bubble.
  always_comb begin
    state_d    = state_q;
    rd_col_d   = rd_col_q;
    rd_bank_d  = rd_bank_q;
    valid_d    = valid_q;
    load       = 1'b0;
    ld_bank    = rd_bank_q;
    ld_col     = '0;
    rd_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          load     = 1'b1;
          valid_d  = 1'b1;
          rd_col_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && out_ready) begin
          if (rd_col_q != LAST_IDX) begin
            rd_col_d = rd_col_q + IDX_W'(1);
            ld_col   = rd_col_d;
            load     = 1'b1;
          end else begin
            rd_release = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            rd_col_d   = '0;
            if (full_q[~rd_bank_q]) begin
              ld_bank = ~rd_bank_q;
              load    = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read FSM: output selection for the column register.
  always_comb begin
    ld_data = ld_bank ? bank1_col : bank0_col;
    ld_tag  = tag_q[ld_bank];
  end

endmodule

// File: tb/tb_idct_transpose_buffer.sv
module tb_idct_transpose_buffer;
  import jpeg_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic [1:0]           channel_in;
  logic [7:0][63:0]     idct_in;
  logic                 in_ready;
  logic                 overflow;
  logic                 valid_out;
  logic                 out_ready;
  logic [7:0][15:0]     col_out;
  logic [1:0]           channel_out;

  always #5 clk = ~clk;

  idct_transpose_buffer #(.IN_W(64), .OUT_W(16), .CH_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .channel_in  (channel_in),
    .idct_in     (idct_in),
    .in_ready    (in_ready),
    .overflow    (overflow),
    .valid_out   (valid_out),
    .out_ready   (out_ready),
    .col_out     (col_out),
    .channel_out (channel_out)
  );

  typedef struct packed {
    logic [7:0][15:0] col;
    logic [1:0]       tag;
  } col_t;

  col_t exp_q[$];
  col_t got_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: blocks held = completed blocks not yet fully emitted.
  int          held, wr_cnt, rd_cnt;
  logic        m_ovf;
  logic [1:0]  m_tag;
  longint      m_rows[8][8];
  logic        prev_stall;
  logic [7:0][15:0] prev_col;
  logic [1:0]  prev_ch;
  logic        rand_ready;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [7:0][63:0] mk_row(input int r, input longint off, input longint mul);
    logic [7:0][63:0] d;
    for (int c = 0; c < 8; c++) d[c] = 64'(mul * longint'(8 * r + c) + off);
    return d;
  endfunction

  // Compare process: checks outputs against the model, then applies the
  // events of the coming edge to the model.
  always @(negedge clk) begin : cmp
    bit   acc;
    col_t e;
    if (rst) begin
      chk("rst_valid_out", 128'(valid_out), 128'(0));
      chk("rst_col_out", 128'(col_out), 128'(0));
      chk("rst_channel_out", 128'(channel_out), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      exp_q.delete();
      held = 0; wr_cnt = 0; rd_cnt = 0; m_ovf = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("in_ready", 128'(in_ready), 128'(held < 2));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      if (prev_stall) begin
        chk("hold_valid", 128'(valid_out), 128'(1));
        chk("hold_col", 128'(col_out), 128'(prev_col));
        chk("hold_chan", 128'(channel_out), 128'(prev_ch));
      end
      if (valid_out) begin
        if (exp_q.size() == 0) chk("extra_col", 128'(valid_out), 128'(0));
        else begin
          chk("col_out", 128'(col_out), 128'(exp_q[0].col));
          chk("channel_out", 128'(channel_out), 128'(exp_q[0].tag));
        end
      end
      prev_stall = valid_out && !out_ready;
      prev_col   = col_out;
      prev_ch    = channel_out;

      acc = (held < 2);
      if (valid_out && out_ready) begin
        got_q.push_back({col_out, channel_out});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rd_cnt++;
        if (rd_cnt == 8) begin rd_cnt = 0; held--; end
      end
      if (valid_in) begin
        if (acc) begin
          for (int c = 0; c < 8; c++) m_rows[wr_cnt][c] = sat16($signed(idct_in[c]));
          if (wr_cnt == 0) m_tag = channel_in;
          wr_cnt++;
          if (wr_cnt == 8) begin
            for (int c = 0; c < 8; c++) begin
              for (int r = 0; r < 8; r++) e.col[r] = 16'(m_rows[r][c]);
              e.tag = m_tag;
              exp_q.push_back(e);
            end
            held++;
            wr_cnt = 0;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_row(input logic [7:0][63:0] d, input logic [1:0] ch, input bit fc);
    int n = 0;
    if (fc) begin
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) chk("in_ready_timeout", 128'(in_ready), 128'(1));
    end
    valid_in   = 1'b1;
    idct_in    = d;
    channel_in = ch;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || valid_out) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 128'(exp_q.size() == 0 && !valid_out), 128'(1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0][63:0] d;
    longint sv[8];
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1; channel_in = '0; idct_in = '0;
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single block, latency and transpose
    got_q.delete();
    for (int r = 0; r < 8; r++) send_row(mk_row(r, 0, 1), CH_CB, 1'b0);
    @(negedge clk); chk("lat_edge_e", 128'(valid_out), 128'(0));
    @(negedge clk); chk("lat_edge_e1", 128'(valid_out), 128'(1));
    drain(100);
    chk("t1_count", 128'(got_q.size()), 128'(8));
    chk("t1_c0r0", 128'(got_q[0].col[0]), 128'(0));
    chk("t1_c0r7", 128'(got_q[0].col[7]), 128'(56));
    chk("t1_c3r5", 128'(got_q[3].col[5]), 128'(43));
    chk("t1_c7r7", 128'(got_q[7].col[7]), 128'(63));
    chk("t1_tag", 128'(got_q[7].tag), 128'(1));
    chk("t1_idle", 128'(valid_out), 128'(0));

    // 2: saturation
    got_q.delete();
    sv = '{40000, -40000, 32767, -32768, 0, 1, -1, 100};
    for (int c = 0; c < 8; c++) d[c] = 64'(sv[c]);
    send_row(d, CH_Y, 1'b0);
    for (int r = 1; r < 8; r++) send_row(mk_row(r, 0, 1), CH_Y, 1'b0);
    drain(100);
    chk("sat_pos", 128'(got_q[0].col[0]), 128'(16'h7fff));
    chk("sat_neg", 128'(got_q[1].col[0]), 128'(16'h8000));
    chk("sat_max_pass", 128'(got_q[2].col[0]), 128'(16'h7fff));
    chk("sat_min_pass", 128'(got_q[3].col[0]), 128'(16'h8000));
    chk("sat_one", 128'(got_q[5].col[0]), 128'(16'h0001));
    chk("sat_m1", 128'(got_q[6].col[0]), 128'(16'hffff));
    chk("sat_100", 128'(got_q[7].col[0]), 128'(16'd100));
    chk("sat_row1", 128'(got_q[0].col[1]), 128'(16'd8));

    // 3: three blocks back to back
    got_q.delete();
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 8; r++) send_row(mk_row(r, 64 * b, 1), 2'(b), 1'b1);
    drain(200);
    chk("t3_count", 128'(got_q.size()), 128'(24));
    chk("t3_ovf", 128'(overflow), 128'(0));
    chk("t3_tag0", 128'(got_q[0].tag), 128'(0));
    chk("t3_tag1", 128'(got_q[8].tag), 128'(1));
    chk("t3_tag2", 128'(got_q[16].tag), 128'(2));
    chk("t3_b2c1r2", 128'(got_q[17].col[2]), 128'(145));

    // 4: output stalled, overflow
    got_q.delete();
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) send_row(mk_row(r, 100 * (b + 1), 1), b ? CH_Y : CH_CR, 1'b0);
    chk("t4_in_ready_low", 128'(in_ready), 128'(0));
    chk("t4_no_ovf_yet", 128'(overflow), 128'(0));
    send_row(mk_row(0, 9999, 1), CH_CB, 1'b0);
    @(negedge clk);
    chk("t4_ovf_set", 128'(overflow), 128'(1));
    out_ready = 1'b1;
    drain(100);
    chk("t4_count", 128'(got_q.size()), 128'(16));
    chk("t4_b1_first", 128'(got_q[8].col[0]), 128'(200));
    chk("t4_b1_last", 128'(got_q[15].col[7]), 128'(263));
    chk("t4_tag0", 128'(got_q[0].tag), 128'(2));
    chk("t4_ovf_sticky", 128'(overflow), 128'(1));

    // 5: random out_ready
    got_q.delete();
    rand_ready = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) send_row(mk_row(r, 1000 * b, 1), CH_CR, 1'b1);
    drain(1000);
    rand_ready = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    chk("t5_count", 128'(got_q.size()), 128'(16));

    // 6: reset mid-block
    got_q.delete();
    for (int r = 0; r < 5; r++) send_row(mk_row(r, 777, 1), CH_Y, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 8; r++) send_row(mk_row(r, 0, -1), CH_CB, 1'b1);
    drain(100);
    chk("t6_count", 128'(got_q.size()), 128'(8));
    chk("t6_c0r1", 128'(got_q[0].col[1]), 128'(16'hfff8));
    chk("t6_c3r2", 128'(got_q[3].col[2]), 128'(16'hffed));
    chk("t6_tag", 128'(got_q[0].tag), 128'(1));
    chk("t6_ovf", 128'(overflow), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
